// File: rtl/vc_buffer.sv
// vc_buffer: single-clock multi-virtual-channel input buffer for a NoC router port.
//
// The block holds n_vc independent circular FIFOs, each 2**addr_len words deep,
// in one shared storage array addressed {vc, ptr}. In each cycle it accepts at
// most one write and one read, and each can target any channel. Read data is
// registered, so the read latency is one cycle.
//
// Ports:
//   clk          in  1          single clock, rising edge
//   rst          in  1          synchronous reset, active-low
//   load         in  1          write request
//   load_vc      in  vc_w       write target channel
//   data_in      in  bit_width  write data
//   consume      in  1          read request
//   consume_vc   in  vc_w       read source channel
//   data_out     out bit_width  registered read data
//   valid_out    out 1          data_out holds a word popped at the last edge
//   out_vc       out vc_w       channel of data_out
//   empty        out n_vc       per-channel count == 0
//   full         out n_vc       per-channel count == depth
//   almost_full  out n_vc       per-channel count >= af_level
//   ovf_err      out 1          sticky, set by a rejected load
//   udf_err      out 1          sticky, set by a rejected consume
module vc_buffer #(
    parameter int bit_width = 16,
    parameter int addr_len  = 3,
    parameter int n_vc      = 4,
    parameter int vc_w      = 2,
    parameter int af_level  = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [vc_w-1:0]      load_vc,
    input  logic [bit_width-1:0] data_in,
    input  logic                 consume,
    input  logic [vc_w-1:0]      consume_vc,
    output logic [bit_width-1:0] data_out,
    output logic                 valid_out,
    output logic [vc_w-1:0]      out_vc,
    output logic [n_vc-1:0]      empty,
    output logic [n_vc-1:0]      full,
    output logic [n_vc-1:0]      almost_full,
    output logic                 ovf_err,
    output logic                 udf_err
);

    localparam int depth = 2 ** addr_len;
    localparam logic [vc_w:0]     nvc_lim   = (vc_w + 1)'(n_vc);
    localparam logic [addr_len:0] depth_lim = (addr_len + 1)'(depth);
    localparam logic [addr_len:0] af_lim    = (addr_len + 1)'(af_level);

    logic [addr_len-1:0]  wr_ptr [n_vc];
    logic [addr_len-1:0]  rd_ptr [n_vc];
    logic [addr_len:0]    count  [n_vc];
    logic [bit_width-1:0] mem    [n_vc*depth];

    logic                     load_in_range;
    logic                     consume_in_range;
    logic                     wr_ok;
    logic                     rd_ok;
    logic [vc_w+addr_len-1:0] wr_addr;
    logic [vc_w+addr_len-1:0] rd_addr;
    logic [n_vc-1:0]          wr_hit;
    logic [n_vc-1:0]          rd_hit;

    // Flags are decoded only from the registered counts, so no input reaches
    // an output combinationally.
    always_comb begin
        for (int v = 0; v < n_vc; v++) begin
            empty[v]       = (count[v] == '0);
            full[v]        = (count[v] == depth_lim);
            almost_full[v] = (count[v] >= af_lim);
        end
    end

    // Out-of-range channel indices are checked before any per-channel array
    // is consulted, so they are rejected cleanly.
    always_comb begin
        load_in_range    = ({1'b0, load_vc} < nvc_lim);
        consume_in_range = ({1'b0, consume_vc} < nvc_lim);
        wr_ok   = 1'b0;
        rd_ok   = 1'b0;
        wr_addr = '0;
        rd_addr = '0;
        if (load && load_in_range) begin
            wr_ok   = !full[load_vc];
            wr_addr = {load_vc, wr_ptr[load_vc]};
        end
        if (consume && consume_in_range) begin
            rd_ok   = !empty[consume_vc];
            rd_addr = {consume_vc, rd_ptr[consume_vc]};
        end
        for (int v = 0; v < n_vc; v++) begin
            wr_hit[v] = wr_ok && (load_vc == vc_w'(v));
            rd_hit[v] = rd_ok && (consume_vc == vc_w'(v));
        end
    end

    // Storage is deliberately not reset. A reset discards the stored words
    // because the pointers and counts are cleared.
    always_ff @(posedge clk) begin
        if (rst && wr_ok) begin
            mem[wr_addr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int v = 0; v < n_vc; v++) begin
                wr_ptr[v] <= '0;
                rd_ptr[v] <= '0;
                count[v]  <= '0;
            end
            data_out  <= '0;
            valid_out <= 1'b0;
            out_vc    <= '0;
            ovf_err   <= 1'b0;
            udf_err   <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr[load_vc] <= wr_ptr[load_vc] + 1'b1;
            end
            if (rd_ok) begin
                data_out           <= mem[rd_addr];
                out_vc             <= consume_vc;
                valid_out          <= 1'b1;
                rd_ptr[consume_vc] <= rd_ptr[consume_vc] + 1'b1;
            end else begin
                valid_out <= 1'b0;
            end
            if (load && !wr_ok) begin
                ovf_err <= 1'b1;
            end
            if (consume && !rd_ok) begin
                udf_err <= 1'b1;
            end
            // A write and a read on the same channel cancel out in the count.
            for (int v = 0; v < n_vc; v++) begin
                if (wr_hit[v] && !rd_hit[v]) begin
                    count[v] <= count[v] + 1'b1;
                end else if (rd_hit[v] && !wr_hit[v]) begin
                    count[v] <= count[v] - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vc_buffer.sv
// tb_vc_buffer: directed stimulus with a queue-based scoreboard for vc_buffer.
// The stimulus pushes the expected {vc, data} pair of every consume that should
// be accepted. A monitor running on the falling edge pops one entry each time
// valid_out is high and compares it with the DUT output.
module tb_vc_buffer;

    logic        clk;
    logic        rst;
    logic        load;
    logic [1:0]  load_vc;
    logic [15:0] data_in;
    logic        consume;
    logic [1:0]  consume_vc;
    logic [15:0] data_out;
    logic        valid_out;
    logic [1:0]  out_vc;
    logic [3:0]  empty;
    logic [3:0]  full;
    logic [3:0]  almost_full;
    logic        ovf_err;
    logic        udf_err;

    int n_cmp = 0;
    int n_bad = 0;
    logic [17:0] exp_q[$];

    vc_buffer #(
        .bit_width(16), .addr_len(3), .n_vc(4), .vc_w(2), .af_level(6)
    ) dut (
        .clk(clk), .rst(rst),
        .load(load), .load_vc(load_vc), .data_in(data_in),
        .consume(consume), .consume_vc(consume_vc),
        .data_out(data_out), .valid_out(valid_out), .out_vc(out_vc),
        .empty(empty), .full(full), .almost_full(almost_full),
        .ovf_err(ovf_err), .udf_err(udf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        load    = 1'b0;
        consume = 1'b0;
    endtask

    // Monitor: every valid output must match the oldest expected word.
    always @(negedge clk) begin
        if (rst && valid_out) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", {14'd0, out_vc, data_out}, 32'hFFFF_FFFF);
            end else begin
                logic [17:0] e;
                e = exp_q.pop_front();
                check("out_data", {16'd0, data_out}, {16'd0, e[15:0]});
                check("out_vc", {30'd0, out_vc}, {30'd0, e[17:16]});
            end
        end
    end

    initial begin
        rst = 1'b0; idle(); load_vc = '0; consume_vc = '0; data_in = '0;
        step(); step();
        check("rst_empty", {28'd0, empty}, 32'hF);
        check("rst_full", {28'd0, full}, 32'h0);
        check("rst_af", {28'd0, almost_full}, 32'h0);
        check("rst_valid", {31'd0, valid_out}, 32'h0);
        check("rst_data", {16'd0, data_out}, 32'h0);
        check("rst_outvc", {30'd0, out_vc}, 32'h0);
        check("rst_ovf", {31'd0, ovf_err}, 32'h0);
        check("rst_udf", {31'd0, udf_err}, 32'h0);
        rst = 1'b1;

        // Fill VC2 with 0x0101..0x0108.
        for (int i = 1; i <= 8; i++) begin
            load = 1'b1; load_vc = 2'd2; data_in = 16'h0100 + 16'(i);
            step();
            check("fill_af2", {31'd0, almost_full[2]}, (i >= 6) ? 32'd1 : 32'd0);
            check("fill_full", {28'd0, full}, (i == 8) ? 32'h4 : 32'h0);
        end
        check("fill_ovf_before", {31'd0, ovf_err}, 32'h0);
        data_in = 16'h0109;
        step();
        check("ovf_set", {31'd0, ovf_err}, 32'h1);
        check("ovf_full_kept", {28'd0, full}, 32'h4);

        // Drain VC2. The rejected 0x0109 must not appear.
        load = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            consume = 1'b1; consume_vc = 2'd2;
            exp_q.push_back({2'd2, 16'h0100 + 16'(i)});
            step();
        end
        idle();
        step();
        check("drain_empty", {28'd0, empty}, 32'hF);
        check("drain_udf", {31'd0, udf_err}, 32'h0);

        // Interleave the VC0 and VC3 loads.
        for (int i = 0; i < 4; i++) begin
            load = 1'b1; load_vc = 2'd0; data_in = 16'hA000 + 16'(i);
            step();
            load_vc = 2'd3; data_in = 16'hB000 + 16'(i);
            step();
        end
        // Read VC3 while loading VC1. The two channels are judged independently.
        for (int i = 0; i < 4; i++) begin
            consume = 1'b1; consume_vc = 2'd3;
            load = 1'b1; load_vc = 2'd1; data_in = 16'hC000 + 16'(i);
            exp_q.push_back({2'd3, 16'hB000 + 16'(i)});
            step();
        end
        load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            consume = 1'b1; consume_vc = 2'd0;
            exp_q.push_back({2'd0, 16'hA000 + 16'(i)});
            step();
        end
        idle();
        step();
        check("inter_empty", {28'd0, empty}, 32'hD);

        // Hold VC1 at four words for 20 cycles. The pointers wrap and the order
        // stays FIFO.
        for (int i = 0; i < 20; i++) begin
            load = 1'b1; load_vc = 2'd1; data_in = 16'hC004 + 16'(i);
            consume = 1'b1; consume_vc = 2'd1;
            exp_q.push_back({2'd1, 16'hC000 + 16'(i)});
            step();
            check("hold_af1", {31'd0, almost_full[1]}, 32'h0);
        end
        idle();
        step();
        check("hold_empty1", {31'd0, empty[1]}, 32'h0);
        check("hold_full1", {31'd0, full[1]}, 32'h0);

        // Load and consume on the empty VC0 in the same cycle: the read is
        // rejected and there is no bypass.
        check("udf_before", {31'd0, udf_err}, 32'h0);
        load = 1'b1; load_vc = 2'd0; data_in = 16'h55AA;
        consume = 1'b1; consume_vc = 2'd0;
        step();
        idle();
        check("udf_set", {31'd0, udf_err}, 32'h1);
        check("udf_novalid", {31'd0, valid_out}, 32'h0);
        check("udf_vc0_loaded", {31'd0, empty[0]}, 32'h0);
        consume = 1'b1; consume_vc = 2'd0;
        exp_q.push_back({2'd0, 16'h55AA});
        step();
        idle();
        step();

        // Bring VC1 to five words, then reset with a load and a consume asserted.
        load = 1'b1; load_vc = 2'd1; data_in = 16'hC018;
        step();
        idle();
        check("pre_rst_data", {16'd0, data_out}, 32'h55AA);
        rst = 1'b0;
        consume = 1'b1; consume_vc = 2'd1;
        load = 1'b1; load_vc = 2'd1; data_in = 16'hDEAD;
        step();
        check("mid_rst_valid", {31'd0, valid_out}, 32'h0);
        check("mid_rst_data", {16'd0, data_out}, 32'h0);
        check("mid_rst_outvc", {30'd0, out_vc}, 32'h0);
        check("mid_rst_empty", {28'd0, empty}, 32'hF);
        check("mid_rst_full", {28'd0, full}, 32'h0);
        check("mid_rst_af", {28'd0, almost_full}, 32'h0);
        check("mid_rst_ovf", {31'd0, ovf_err}, 32'h0);
        check("mid_rst_udf", {31'd0, udf_err}, 32'h0);
        rst = 1'b1;
        load = 1'b0;
        consume = 1'b1; consume_vc = 2'd1;
        step();
        idle();
        check("post_rst_udf", {31'd0, udf_err}, 32'h1);
        check("post_rst_valid", {31'd0, valid_out}, 32'h0);
        step();
        step();

        check("queue_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vc_buffer.md
# vc_buffer

Single-clock, parametrised, multi-virtual-channel input buffer for a NoC router port, successor to the dual-clock single-queue `buffer`. It holds `n_vc` independent circular FIFOs of `2**addr_len` words in one shared storage array. It accepts at most one write and one read per cycle, each to any channel, and exposes per-channel empty, full and almost-full flags. Sticky overflow and underflow error flags replace the old "consume never arrives when empty" assumption.

## Interface
- `bit_width`, 16, flit width in bits.
- `addr_len`, 3, log2 of per-channel depth; depth D = 2**addr_len.
- `n_vc`, 4, number of virtual channels, 1..16.
- `vc_w`, 2, channel index width; must satisfy 2**vc_w >= n_vc, minimum 1.
- `af_level`, 6, almost-full threshold, 1..D.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous reset, active-low. Sampled on rising `clk`; 0 resets the block.
- `load` in 1: write request.
- `load_vc` in vc_w: target channel of the write.
- `data_in` in bit_width: write data.
- `consume` in 1: read request.
- `consume_vc` in vc_w: source channel of the read.
- `data_out` out bit_width: registered read data.
- `valid_out` out 1: `data_out` holds a word popped in the previous cycle.
- `out_vc` out vc_w: channel of the current `data_out`.
- `empty` out n_vc: bit i = channel i count == 0.
- `full` out n_vc: bit i = channel i count == D.
- `almost_full` out n_vc: bit i = channel i count >= `af_level`.
- `ovf_err` out 1: sticky; set by a rejected load.
- `udf_err` out 1: sticky; set by a rejected consume.

## Operation
- Per-channel state: `wr_ptr` and `rd_ptr` (addr_len bits each, natural wrap D-1 -> 0) and `count` (addr_len+1 bits, range 0..D).
- Storage has n_vc*D words, addressed `{vc, ptr}`. It is not reset.
- Write accept: `load && load_vc < n_vc && !full[load_vc]`.
  - Effect: store `data_in` at `{load_vc, wr_ptr}`, increment `wr_ptr`.
- Read accept: `consume && consume_vc < n_vc && !empty[consume_vc]`.
  - Effect: `data_out <= mem[{consume_vc, rd_ptr}]`, `out_vc <= consume_vc`, `valid_out <= 1`, increment `rd_ptr`.
- No accepted read: `valid_out <= 0`; `data_out` and `out_vc` hold their values.
- Flags are evaluated from the registered `count` before the current edge.
- Same channel, load and consume in one cycle:
  - Count neither 0 nor D: both accepted, `count` unchanged.
  - Count == D: read accepted, write rejected.
  - Count == 0: write accepted, read rejected. No bypass; `udf_err` is set.
- Different channels, load and consume in one cycle: each is judged independently and both may be accepted.
- Count update: +1 (write only), -1 (read only), or unchanged.
- Rejected load sets `ovf_err`. Rejected consume sets `udf_err`. This includes out-of-range `vc` (>= n_vc). Both flags clear only on reset.
- A rejected request changes no pointer, count or storage.
- Reset (`rst`=0 at an edge) takes effect in any state, including mid-stream, and discards all stored words. After reset:
  - all pointers and counts = 0; `empty` = all ones; `full` = 0; `almost_full` = 0;
  - `valid_out` = 0; `data_out` = 0; `out_vc` = 0; `ovf_err` = 0; `udf_err` = 0.
  - A load or consume asserted in a reset cycle is ignored.

## Timing
- Flags are combinational decodes of the `count` registers, glitch-free relative to `clk`. They update the cycle after the accepted operation.
- Write-to-read: a word loaded at edge t can be consumed at edge t+1 and appears on `data_out` after edge t+1. Minimum end-to-end latency is 2 cycles.
- Read latency: 1 cycle. Request at edge t, `data_out`/`valid_out` valid from t until t+1.
- Throughput: 1 write + 1 read per cycle sustained, per block.
- No combinational path from any input to any output.

## Test plan
- Reset then fill VC2 with 8 words 0x0101..0x0108:
  - `full` = 0100, `almost_full[2]` rises after the 6th word;
  - a 9th load sets `ovf_err`, and word 0x0109 is never read.
- Drain VC2 with 8 consecutive consumes: `data_out` = 0x0101..0x0108 on consecutive cycles with `valid_out`=1 and `out_vc`=2, then `empty[2]`=1.
- Interleave VC0 loads (0xA000+i) and VC3 loads (0xB000+i), then read VC3 then VC0. Each channel returns its own words in order with no cross-talk.
- Hold VC1 at count 4 with load+consume on VC1 for 20 cycles: `count` stays 4, pointers wrap past 7, and output order is strictly FIFO.
- Empty VC0 with simultaneous load(0x55AA)+consume on VC0: `udf_err`=1, `valid_out`=0, then `count[0]`=1 and the next consume returns 0x55AA.
- Drive `rst`=0 mid-stream with 5 words in VC1 and a consume asserted. Next cycle all outputs show reset values, and a subsequent consume on VC1 sets `udf_err`.
